// File: rtl/imm_pkg.sv
// Shared types and range helpers for the RISC-V immediate encoder.
// Format selector, per-format signed range widths, and the range/alignment check.
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam int IMM_W_I = 12;
  localparam int IMM_W_S = 12;
  localparam int IMM_W_B = 13;
  localparam int IMM_W_J = 21;

  // An immediate fits when every bit above its sign bit replicates the sign bit.
  function automatic logic imm_range_err(input imm_src_e src, input logic [31:0] imm);
    logic err;
    case (src)
      IMM_I:   err = !((&imm[31:IMM_W_I-1]) || !(|imm[31:IMM_W_I-1]));
      IMM_S:   err = !((&imm[31:IMM_W_S-1]) || !(|imm[31:IMM_W_S-1]));
      IMM_B:   err = !((&imm[31:IMM_W_B-1]) || !(|imm[31:IMM_W_B-1])) || imm[0];
      IMM_J:   err = !((&imm[31:IMM_W_J-1]) || !(|imm[31:IMM_W_J-1])) || imm[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational field packing: scatters the immediate into its format's bit
// positions and keeps every other bit from the base instruction.
module imm_pack
  import imm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  imm_src_e         src,
  input  logic [20:0]      imm,
  input  logic [WIDTH-1:0] base,
  input  logic             err,
  output logic [WIDTH-1:0] instr
);

  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] field_s;

  // Select the immediate bit mask and scattered field for the format.
  always_comb begin
    mask_s  = 32'h0000_0000;
    field_s = 32'h0000_0000;
    case (src)
      IMM_I: begin
        mask_s  = 32'hFFF0_0000;
        field_s = {imm[11:0], 20'h0_0000};
      end
      IMM_S: begin
        mask_s  = 32'hFE00_0F80;
        field_s = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
      end
      IMM_B: begin
        mask_s  = 32'hFE00_0F80;
        field_s = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
      end
      IMM_J: begin
        mask_s  = 32'hFFFF_F000;
        field_s = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
      end
      default: begin
        mask_s  = 32'h0000_0000;
        field_s = 32'h0000_0000;
      end
    endcase
    instr = (base & ~mask_s) | (err ? 32'h0000_0000 : field_s);
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage 1 captures the request and
// its range check, stage 2 holds the packed instruction until it is consumed.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ImmSrc,
  input  logic [WIDTH-1:0] Imm,
  input  logic [WIDTH-1:0] BaseInstr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Instr,
  output logic             ImmErr,
  output logic [7:0]       ErrCount
);

  imm_src_e         in_src_s;
  logic             in_err_s;
  logic             s1_en_s;
  logic             s2_en_s;
  logic [WIDTH-1:0] pack_instr_s;

  logic             s1_valid_r;
  imm_src_e         s1_src_r;
  logic [20:0]      s1_imm_r;
  logic [WIDTH-1:0] s1_base_r;
  logic             s1_err_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_instr_r;
  logic             s2_err_r;
  logic [7:0]       err_count_r;

  assign in_src_s = imm_src_e'(ImmSrc);
  assign in_err_s = imm_range_err(in_src_s, Imm);

  // Stage 2 loads when empty or draining; stage 1 moves whenever stage 2 can take it.
  assign s2_en_s = !s2_valid_r || OutReady;
  assign s1_en_s = !s1_valid_r || s2_en_s;
  assign InReady = s1_en_s;

  // Stage 1: request capture; only the low 21 immediate bits feed packing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_src_r   <= IMM_I;
      s1_imm_r   <= 21'h00_0000;
      s1_base_r  <= 32'h0000_0000;
      s1_err_r   <= 1'b0;
    end else if (s1_en_s) begin
      s1_valid_r <= InValid;
      if (InValid) begin
        s1_src_r  <= in_src_s;
        s1_imm_r  <= Imm[20:0];
        s1_base_r <= BaseInstr;
        s1_err_r  <= in_err_s;
      end
    end
  end

  imm_pack #(.WIDTH(WIDTH)) u_pack (
    .src   (s1_src_r),
    .imm   (s1_imm_r),
    .base  (s1_base_r),
    .err   (s1_err_r),
    .instr (pack_instr_s)
  );

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_instr_r <= 32'h0000_0000;
      s2_err_r   <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_instr_r <= pack_instr_s;
        s2_err_r   <= s1_err_r;
      end
    end
  end

  // Saturating count of delivered error results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= 8'h00;
    end else if (s2_valid_r && OutReady && s2_err_r && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

  assign OutValid = s2_valid_r;
  assign Instr    = s2_instr_r;
  assign ImmErr   = s2_err_r;
  assign ErrCount = err_count_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: scoreboard model using RISC-V immediate
// decoding plus directed literal vectors.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid, InReady, OutValid, OutReady, ImmErr;
  logic [1:0]  ImmSrc;
  logic [31:0] Imm, BaseInstr, Instr;
  logic [7:0]  ErrCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  req_t        q[$];
  logic [31:0] log_q[$];
  int          exp_cnt = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_i;
  logic        hold_e;
  logic        rnd_ready = 1'b0;

  always #5 clk = ~clk;

  imm_encoder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .Imm(Imm), .BaseInstr(BaseInstr),
    .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr),
    .ImmErr(ImmErr), .ErrCount(ErrCount)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] src);
    case (src)
      2'd0, 2'd1: return 12;
      2'd2:       return 13;
      default:    return 21;
    endcase
  endfunction

  // Legal = signed value within the format's range and, for B/J, even.
  function automatic bit legal(input logic [1:0] src, input logic [31:0] imm);
    longint v;
    longint lim;
    v   = longint'($signed(imm));
    lim = longint'(1) <<< (width_of(src) - 1);
    if (src[1] && imm[0]) return 1'b0;
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic logic [31:0] imm_mask(input logic [1:0] src);
    case (src)
      2'd0:       return 32'hFFF0_0000;
      2'd1, 2'd2: return 32'hFE00_0F80;
      default:    return 32'hFFFF_F000;
    endcase
  endfunction

  // Standard RISC-V sign extender (decoder side).
  function automatic logic [31:0] sign_ext(input logic [1:0] src, input logic [31:0] ins);
    case (src)
      2'd0:    return {{20{ins[31]}}, ins[31:20]};
      2'd1:    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      2'd2:    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      default: return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endcase
  endfunction

  // Compare process: scoreboard, stability under stall, error counter.
  always @(negedge clk) begin
    req_t r;
    bit   e;
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      hold_v  = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(OutValid), 32'd1);
        chk("hold_instr", Instr, hold_i);
        chk("hold_err", 32'(ImmErr), 32'(hold_e));
      end
      chk("errcount", 32'(ErrCount), 32'(exp_cnt));
      if (OutValid && OutReady) begin
        log_q.push_back(Instr);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output got %h required none", Instr);
        end else begin
          r = q.pop_front();
          e = !legal(r.src, r.imm);
          chk("immerr", 32'(ImmErr), 32'(e));
          chk("base_bits", Instr & ~imm_mask(r.src), r.base & ~imm_mask(r.src));
          if (e) chk("err_imm_zero", Instr & imm_mask(r.src), 32'h0000_0000);
          else   chk("sign_ext", sign_ext(r.src, Instr), r.imm);
          if (e && exp_cnt < 255) exp_cnt++;
        end
      end
      hold_v = OutValid && !OutReady;
      hold_i = Instr;
      hold_e = ImmErr;
      if (InValid && InReady) q.push_back('{ImmSrc, Imm, BaseInstr});
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 OutReady = ($urandom_range(0, 3) != 0);
    end
  end

  // Present a request and return #1 after the edge that accepts it.
  task automatic send(input logic [1:0] s, input logic [31:0] v, input logic [31:0] b);
    bit ok;
    ok        = 1'b0;
    ImmSrc    = s;
    Imm       = v;
    BaseInstr = b;
    InValid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (InReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got InReady=0 required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !OutValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending required 0", q.size());
    end
  endtask

  // One request with literal result exactly two cycles after acceptance.
  task automatic single(input string name, input logic [1:0] s, input logic [31:0] v,
                        input logic [31:0] b, input logic [31:0] exp_i, input logic exp_e);
    send(s, v, b);
    InValid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, 32'(OutValid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(OutValid), 32'd1);
    chk({name, "_instr"}, Instr, exp_i);
    chk({name, "_err"}, 32'(ImmErr), 32'(exp_e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    ImmSrc = 2'd0; Imm = 32'h0; BaseInstr = 32'h0;
    @(negedge clk);
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_inready", 32'(InReady), 32'd1);
    chk("rst_instr", Instr, 32'h0000_0000);
    chk("rst_immerr", 32'(ImmErr), 32'd0);
    chk("rst_errcount", 32'(ErrCount), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    single("i_neg1", 2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    single("s_8",    2'd1, 32'd8,         32'h0000_2023, 32'h0000_2423, 1'b0);
    single("b_m4",   2'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    single("j_2048", 2'd3, 32'd2048,      32'h0000_006F, 32'h0010_006F, 1'b0);
    single("i_2048", 2'd0, 32'd2048,      32'h0000_0013, 32'h0000_0013, 1'b1);
    chk("errcount_1", 32'(ErrCount), 32'd1);
    single("b_3",    2'd2, 32'd3,         32'h0000_0063, 32'h0000_0063, 1'b1);
    chk("errcount_2", 32'(ErrCount), 32'd2);

    // Back-pressure: three back-to-back requests with the consumer stalled.
    OutReady = 1'b0;
    send(2'd0, 32'd1, 32'h0000_0013);
    send(2'd0, 32'd2, 32'h0000_0013);
    ImmSrc = 2'd0; Imm = 32'd3; BaseInstr = 32'h0000_0013; InValid = 1'b1;
    @(negedge clk);
    chk("bp_inready", 32'(InReady), 32'd0);
    chk("bp_head", Instr, 32'h0010_0013);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 OutReady = 1'b1;
    send(2'd0, 32'd3, 32'h0000_0013);
    InValid = 1'b0;
    drain();
    chk("bp_order0", log_q[log_q.size()-3], 32'h0010_0013);
    chk("bp_order1", log_q[log_q.size()-2], 32'h0020_0013);
    chk("bp_order2", log_q[log_q.size()-1], 32'h0030_0013);

    // Random legal immediates with a randomly stalling consumer.
    rnd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  s;
      int          w;
      logic [31:0] r;
      logic [31:0] v;
      s = 2'($urandom_range(0, 3));
      w = width_of(s);
      r = $urandom() << (32 - w);
      v = $signed(r) >>> (32 - w);
      if (s[1]) v[0] = 1'b0;
      send(s, v, $urandom());
    end
    InValid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 OutReady = 1'b1;
    drain();

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send(2'd0, 32'h0000_1000, 32'h0000_0013);
    InValid = 1'b0;
    drain();
    chk("errcount_sat", 32'(ErrCount), 32'd255);

    // Reset with two requests in flight.
    @(posedge clk);
    #1 OutReady = 1'b0;
    send(2'd1, 32'd4, 32'h0000_2023);
    send(2'd1, 32'd5, 32'h0000_2023);
    InValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_outvalid", 32'(OutValid), 32'd0);
    chk("midrst_inready", 32'(InReady), 32'd1);
    chk("midrst_errcount", 32'(ErrCount), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(OutValid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction and immediate width (only 32 supported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port InValid  input  1  request valid.
REQ-005 SHALL have port InReady  output  1  encoder can accept a request this cycle.
REQ-006 SHALL have port ImmSrc  input  2  format: 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have port Imm  input  WIDTH  signed byte-offset immediate to encode.
REQ-008 SHALL have port BaseInstr  input  WIDTH  instruction holding opcode/rd/rs1/rs2/funct fields; its immediate bit positions are ignored.
REQ-009 SHALL have port OutValid  output  1  Instr valid.
REQ-010 SHALL have port OutReady  input  1  consumer accepts Instr.
REQ-011 SHALL have port Instr  output  WIDTH  encoded instruction.
REQ-012 SHALL have port ImmErr  output  1  Imm out of range or misaligned for this Instr.
REQ-013 SHALL have port ErrCount  output  8  saturating count of accepted error outputs.

Function
REQ-014 SHALL accept a request when InValid && InReady.
REQ-015 SHALL deliver a result when OutValid && OutReady.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers request and range check, stage 2 registers packed Instr/ImmErr; latency 2 cycles with no stall.
REQ-017 SHALL drive InReady = !s1_valid || !s2_valid || OutReady (stage 1 advances when stage 2 is empty or draining).
REQ-018 SHALL hold Instr, ImmErr, OutValid stable while OutValid && !OutReady.
REQ-019 SHALL sustain one transaction per cycle with OutReady held high.
REQ-020 SHALL preserve request order; no drop, no duplication.
REQ-021 SHALL flag I/S range error unless Imm[31:11] all equal.
REQ-022 SHALL flag B error unless Imm[31:12] all equal and Imm[0]==0.
REQ-023 SHALL flag J error unless Imm[31:20] all equal and Imm[0]==0.
REQ-024 SHALL pack I as Instr[31:20]=Imm[11:0].
REQ-025 SHALL pack S as Instr[31:25]=Imm[11:5], Instr[11:7]=Imm[4:0].
REQ-026 SHALL pack B as Instr[31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11].
REQ-027 SHALL pack J as Instr[31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12].
REQ-028 SHALL copy all non-immediate bit positions from BaseInstr.
REQ-029 SHALL, on error, set ImmErr=1 and force all immediate bit positions to 0.
REQ-030 SHALL increment ErrCount on each output handshake with ImmErr=1.
REQ-031 SHALL saturate ErrCount at 255.

Reset
REQ-032 SHALL, while rst high, clear OutValid, both stage valids, Instr, ImmErr and ErrCount to 0 asynchronously.
REQ-033 SHALL hold InReady at 1 while rst is high.
REQ-034 SHALL discard in-flight requests on reset mid-operation; none emerge afterwards.

Structure
REQ-035 SHALL take the ImmSrc enum (IMM_I, IMM_S, IMM_B, IMM_J) and per-format range widths (12, 12, 13, 21) from a shared package, imm_pkg.
REQ-036 SHALL place the combinational field packing in one sub-module, imm_pack, instantiated between stage 1 and stage 2.

Verification
REQ-037 SHALL cover: I, Imm=0xFFFFFFFF, BaseInstr=0x00000013 -> Instr=0xFFF00013, ImmErr=0, 2 cycles after acceptance.
REQ-038 SHALL cover: S, Imm=8, BaseInstr=0x00002023 -> 0x00002423; B, Imm=-4, BaseInstr=0x00000063 -> 0xFE000EE3; J, Imm=2048, BaseInstr=0x0000006F -> 0x0010006F.
REQ-039 SHALL cover: I, Imm=2048 -> Instr=0x00000013, ImmErr=1, ErrCount=1; then B, Imm=3 -> ImmErr=1, ErrCount=2.
REQ-040 SHALL cover: three back-to-back requests with OutReady low for 3 cycles -> InReady drops once both stages are full, outputs stable, all three delivered in order.
REQ-041 SHALL cover: 300 error requests -> ErrCount stops at 255; rst pulse with two requests in flight -> OutValid=0 and no stale output.
REQ-042 SHALL cover: random legal Imm/ImmSrc -> feeding Instr to SignExtender returns Imm exactly.
